// File: rtl/carpark_gate_sched_if.sv
// Lane-side handshake bundle for the car park barrier scheduler.
// The master drives requests and pass strobes; the slave is the scheduler.
interface carpark_gate_sched_if #(
  parameter int CNT_W = 7
);
  logic             req_in;
  logic             req_out;
  logic             pass_in;
  logic             pass_out;
  logic             gate_open;
  logic             grant_in;
  logic             grant_out;
  logic             deny_in;
  logic             deny_out;
  logic             dir_out;
  logic             timeout;
  logic [CNT_W-1:0] count;
  logic             full;

  modport master (
    output req_in, req_out, pass_in, pass_out,
    input  gate_open, grant_in, grant_out, deny_in, deny_out,
           dir_out, timeout, count, full
  );

  modport slave (
    input  req_in, req_out, pass_in, pass_out,
    output gate_open, grant_in, grant_out, deny_in, deny_out,
           dir_out, timeout, count, full
  );
endinterface

// File: rtl/carpark_gate_sched.sv
// Shared barrier gate scheduler: arbitrates entry/exit lanes, times the
// open/close phases and owns the authoritative occupancy count.
module carpark_gate_sched #(
  parameter int CAPACITY     = 99,
  parameter int CNT_W        = 7,
  parameter int OPEN_CYCLES  = 50000000,
  parameter int CLOSE_CYCLES = 25000000,
  parameter int TMR_W        = 26
) (
  input  logic                clk,
  input  logic                reset_n,
  carpark_gate_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLOSING} state_t;

  localparam logic [CNT_W-1:0] CAP_V      = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_count;
  logic             r_dir;
  logic             r_gate_open;
  logic             r_grant_in;
  logic             r_grant_out;

  logic w_full;
  logic w_empty;
  logic w_elig_in;
  logic w_elig_out;
  logic w_take_in;
  logic w_take_out;
  logic w_inc;
  logic w_dec;

  assign w_full     = (r_count == CAP_V);
  assign w_empty    = (r_count == '0);
  assign w_elig_in  = bus.req_in & ~w_full;
  assign w_elig_out = bus.req_out & ~w_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_count     <= '0;
      r_dir       <= 1'b1;
      r_gate_open <= 1'b0;
      r_grant_in  <= 1'b0;
      r_grant_out <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_gate_open <= (w_next_state == OPEN_IN) || (w_next_state == OPEN_OUT);
      r_grant_in  <= w_take_in;
      r_grant_out <= w_take_out;
      if (w_take_in)
        r_dir <= 1'b0;
      else if (w_take_out)
        r_dir <= 1'b1;
      // Timer restarts at every phase boundary and rests at zero in IDLE.
      if ((w_next_state != r_state) || (r_state == IDLE))
        r_timer <= '0;
      else
        r_timer <= r_timer + 1'b1;
      if (w_inc && !w_full)
        r_count <= r_count + 1'b1;
      else if (w_dec && !w_empty)
        r_count <= r_count - 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_take_in    = 1'b0;
    w_take_out   = 1'b0;
    w_inc        = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie the lane opposite to the last grant wins.
        if (w_elig_in && (!w_elig_out || r_dir)) begin
          w_take_in    = 1'b1;
          w_next_state = OPEN_IN;
        end else if (w_elig_out) begin
          w_take_out   = 1'b1;
          w_next_state = OPEN_OUT;
        end
      end
      OPEN_IN: begin
        if (bus.pass_in) begin
          w_inc        = 1'b1;
          w_next_state = CLOSING;
        end else if (r_timer == OPEN_LAST) begin
          w_next_state = CLOSING;
        end
      end
      OPEN_OUT: begin
        if (bus.pass_out) begin
          w_dec        = 1'b1;
          w_next_state = CLOSING;
        end else if (r_timer == OPEN_LAST) begin
          w_next_state = CLOSING;
        end
      end
      CLOSING: begin
        if (r_timer == CLOSE_LAST)
          w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.gate_open = r_gate_open;
    bus.grant_in  = r_grant_in;
    bus.grant_out = r_grant_out;
    bus.dir_out   = r_dir;
    bus.count     = r_count;
    bus.full      = w_full;
    bus.deny_in   = (r_state == IDLE) & bus.req_in & w_full;
    bus.deny_out  = (r_state == IDLE) & bus.req_out & w_empty;
    bus.timeout   = 1'b0;
    if (r_state == OPEN_IN)
      bus.timeout = ~bus.pass_in & (r_timer == OPEN_LAST);
    else if (r_state == OPEN_OUT)
      bus.timeout = ~bus.pass_out & (r_timer == OPEN_LAST);
  end
endmodule

// File: tb/tb_carpark_gate_sched.sv
// Directed bench for carpark_gate_sched with a cycle-level lane model
// compared every cycle, plus literal expectations at key points.
module tb_carpark_gate_sched;
  localparam int CAP   = 3;
  localparam int CNT_W = 7;
  localparam int OPEN  = 8;
  localparam int CLOSE = 4;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  carpark_gate_sched_if #(.CNT_W(CNT_W)) bus ();

  carpark_gate_sched #(
    .CAPACITY(CAP), .CNT_W(CNT_W), .OPEN_CYCLES(OPEN),
    .CLOSE_CYCLES(CLOSE), .TMR_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Model: mode 0 idle, 1 entry open, 2 exit open, 3 closing; m_t = 1-based cycle in phase.
  int m_mode, m_cnt, m_t;
  bit m_dir, m_gi, m_go;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_cnt = 0; m_t = 0; m_dir = 1'b1; m_gi = 1'b0; m_go = 1'b0;
    end else begin
      m_gi = 1'b0;
      m_go = 1'b0;
      case (m_mode)
        0: begin
          if (bus.req_in && m_cnt < CAP && (!(bus.req_out && m_cnt > 0) || m_dir)) begin
            m_mode = 1; m_dir = 1'b0; m_gi = 1'b1; m_t = 1;
          end else if (bus.req_out && m_cnt > 0) begin
            m_mode = 2; m_dir = 1'b1; m_go = 1'b1; m_t = 1;
          end
        end
        1, 2: begin
          if ((m_mode == 1 && bus.pass_in) || (m_mode == 2 && bus.pass_out)) begin
            if (m_mode == 1 && m_cnt < CAP) m_cnt = m_cnt + 1;
            if (m_mode == 2 && m_cnt > 0)   m_cnt = m_cnt - 1;
            m_mode = 3; m_t = 1;
          end else if (m_t == OPEN) begin
            m_mode = 3; m_t = 1;
          end else begin
            m_t = m_t + 1;
          end
        end
        default: begin
          if (m_t == CLOSE) begin m_mode = 0; m_t = 0; end
          else m_t = m_t + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    bit e_to;
    e_to = (m_mode == 1 && m_t == OPEN && !bus.pass_in) ||
           (m_mode == 2 && m_t == OPEN && !bus.pass_out);
    chk("m_gate_open", 32'(bus.gate_open), 32'(m_mode == 1 || m_mode == 2));
    chk("m_grant_in",  32'(bus.grant_in),  32'(m_gi));
    chk("m_grant_out", 32'(bus.grant_out), 32'(m_go));
    chk("m_deny_in",   32'(bus.deny_in),   32'(m_mode == 0 && bus.req_in && m_cnt == CAP));
    chk("m_deny_out",  32'(bus.deny_out),  32'(m_mode == 0 && bus.req_out && m_cnt == 0));
    chk("m_dir_out",   32'(bus.dir_out),   32'(m_dir));
    chk("m_timeout",   32'(bus.timeout),   32'(e_to));
    chk("m_count",     32'(bus.count),     32'(m_cnt));
    chk("m_full",      32'(bus.full),      32'(m_cnt == CAP));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Waits (bounded) for a grant, checks which lane won, drops that lane's request.
  task automatic expect_grant(input string nm, input int exp_which);
    int which;
    which = 0;
    for (int i = 0; i < 40 && which == 0; i++) begin
      step();
      if (bus.grant_in) which = 1;
      else if (bus.grant_out) which = 2;
    end
    chk(nm, 32'(which), 32'(exp_which));
    if (which == 1) bus.req_in = 1'b0;
    if (which == 2) bus.req_out = 1'b0;
  endtask

  // Called in open cycle 1; asserts the given pass strobes during open cycle k.
  task automatic pass_at(input int k, input bit pin, input bit pout);
    repeat (k - 1) step();
    bus.pass_in  = pin;
    bus.pass_out = pout;
    step();
    bus.pass_in  = 1'b0;
    bus.pass_out = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bus.req_in = 1'b0; bus.req_out = 1'b0; bus.pass_in = 1'b0; bus.pass_out = 1'b0;
    repeat (3) step();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_dir", 32'(bus.dir_out), 1);
    chk("rst_gate", 32'(bus.gate_open), 0);
    reset_n = 1'b1;
    step();

    // Single entry, pass on 3rd open cycle
    bus.req_in = 1'b1;
    expect_grant("s1_grant", 1);
    chk("s1_gate_up", 32'(bus.gate_open), 1);
    chk("s1_dir", 32'(bus.dir_out), 0);
    step();
    chk("s1_grant_1cyc", 32'(bus.grant_in), 0);
    pass_at(2, 1'b1, 1'b0);
    chk("s1_count", 32'(bus.count), 1);
    chk("s1_gate_down", 32'(bus.gate_open), 0);

    // Fill to capacity
    bus.req_in = 1'b1;
    expect_grant("fill2_grant", 1);
    pass_at(1, 1'b1, 1'b0);
    chk("fill2_count", 32'(bus.count), 2);
    bus.req_in = 1'b1;
    expect_grant("fill3_grant", 1);
    pass_at(5, 1'b1, 1'b0);
    chk("fill3_count", 32'(bus.count), 3);
    chk("fill3_full", 32'(bus.full), 1);

    // Capacity limit: entry denied while full
    repeat (CLOSE) step();
    bus.req_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("cap_deny_in", 32'(bus.deny_in), 1);
      chk("cap_no_grant", 32'(bus.grant_in), 0);
      chk("cap_gate", 32'(bus.gate_open), 0);
      step();
    end
    bus.req_out = 1'b1;
    expect_grant("cap_exit_grant", 2);
    pass_at(2, 1'b0, 1'b1);
    chk("cap_exit_count", 32'(bus.count), 2);

    // Tie with dir_out=1 -> entry
    bus.req_out = 1'b1;
    expect_grant("tie_dir1_grant", 1);
    pass_at(1, 1'b1, 1'b0);
    chk("tie_count3", 32'(bus.count), 3);
    bus.req_in = 1'b1;
    expect_grant("tie_full_grant", 2);
    pass_at(3, 1'b0, 1'b1);
    chk("tie_count2", 32'(bus.count), 2);
    bus.req_out = 1'b1;
    bus.req_in  = 1'b1;
    expect_grant("tie_after_exit", 1);

    // Timeout with no pass (req_out still pending)
    repeat (6) step();
    #1 chk("to_cycle7", 32'(bus.timeout), 0);
    step();
    #1 chk("to_cycle8", 32'(bus.timeout), 1);
    step();
    chk("to_after", 32'(bus.timeout), 0);
    chk("to_count", 32'(bus.count), 2);
    chk("to_gate", 32'(bus.gate_open), 0);

    // Pending exit; pass_in ignored while exit open
    expect_grant("exit_grant", 2);
    pass_at(2, 1'b1, 1'b0);
    chk("exit_ign_in", 32'(bus.count), 2);
    pass_at(1, 1'b0, 1'b1);
    chk("exit_count", 32'(bus.count), 1);

    // Pass on the terminal open cycle wins over timeout
    bus.req_in = 1'b1;
    expect_grant("term_grant", 1);
    repeat (7) step();
    bus.pass_in = 1'b1;
    #1 chk("term_no_to", 32'(bus.timeout), 0);
    step();
    bus.pass_in = 1'b0;
    chk("term_count", 32'(bus.count), 2);

    // Drain to empty
    bus.req_out = 1'b1;
    expect_grant("drain1", 2);
    pass_at(1, 1'b0, 1'b1);
    bus.req_out = 1'b1;
    expect_grant("drain2", 2);
    pass_at(1, 1'b0, 1'b1);
    chk("drain_count", 32'(bus.count), 0);

    // Empty exit denied, stray passes in IDLE
    repeat (CLOSE) step();
    bus.req_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("empty_deny_out", 32'(bus.deny_out), 1);
      chk("empty_no_grant", 32'(bus.grant_out), 0);
      step();
    end
    bus.pass_in = 1'b1;
    step();
    bus.pass_in = 1'b0;
    bus.pass_out = 1'b1;
    step();
    bus.pass_out = 1'b0;
    chk("stray_count", 32'(bus.count), 0);
    bus.req_out = 1'b0;

    // pass_out during OPEN_IN ignored
    bus.req_in = 1'b1;
    expect_grant("ign_grant", 1);
    pass_at(2, 1'b0, 1'b1);
    chk("ign_out_count", 32'(bus.count), 0);
    pass_at(1, 1'b1, 1'b0);
    chk("ign_then_in", 32'(bus.count), 1);

    // Reset in the middle of an exit open phase
    bus.req_out = 1'b1;
    expect_grant("mid_grant", 2);
    step();
    #1 reset_n = 1'b0;
    #1;
    chk("mid_gate", 32'(bus.gate_open), 0);
    chk("mid_count", 32'(bus.count), 0);
    chk("mid_dir", 32'(bus.dir_out), 1);
    bus.req_out = 1'b0;
    bus.req_in  = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    chk("rel_grant_in", 32'(bus.grant_in), 1);
    bus.req_in = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/carpark_gate_sched.md
Name: carpark_gate_sched

Overview:
Schedules a single shared barrier gate between an entry lane and an exit lane of the car park.
- Arbitrates between lane requests and enforces the capacity limit.
- Times the open and close phases of the gate.
- Maintains the authoritative occupancy count, which goes to seven_seg_ctrl for display.
- Pass strobes come from the debounced carpark_fsm enter/exit pulses.

Parameters:
CAPACITY, 99, maximum occupancy; must be ≤ 2^CNT_W-1
CNT_W, 7, occupancy counter width
OPEN_CYCLES, 50000000, clk cycles the gate stays open waiting for a car before timing out
CLOSE_CYCLES, 25000000, clk cycles the gate is held closed after each open phase
TMR_W, 26, phase timer width; must hold max(OPEN_CYCLES, CLOSE_CYCLES)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
req_in  in  1  entry lane request, level, held by requester until grant_in or deny_in
req_out  in  1  exit lane request, level, held until grant_out or deny_out
pass_in  in  1  1-cycle pulse, car completed entry (carpark_fsm enter)
pass_out  in  1  1-cycle pulse, car completed exit (carpark_fsm exit)
gate_open  out  1  barrier raise command
grant_in  out  1  1-cycle pulse, entry granted
grant_out  out  1  1-cycle pulse, exit granted
deny_in  out  1  level, entry refused (park full)
deny_out  out  1  level, exit refused (park empty)
dir_out  out  1  current/last granted direction, 0=entry 1=exit
timeout  out  1  1-cycle pulse, open phase expired with no pass
count  out  CNT_W  current occupancy
full  out  1  count == CAPACITY

Behaviour:
- Reset (reset_n=0, async): state=IDLE, count=0, timer=0, dir_out=1 (entry wins first tie), gate_open=0, all pulses 0. Mid-operation reset drops gate_open immediately and discards any pending pass.
- FSM states: IDLE, OPEN_IN, OPEN_OUT, CLOSING. gate_open=1 only in OPEN_IN/OPEN_OUT, registered from state.
- IDLE eligibility:
  - entry eligible = req_in & ~full
  - exit eligible = req_out & (count!=0)
- IDLE arbitration:
  - Only one eligible: grant it.
  - Both eligible: grant the direction opposite to dir_out (round-robin).
- On grant:
  - Next state OPEN_IN/OPEN_OUT.
  - grant_x pulses on the same edge the state changes, high for exactly 1 cycle.
  - dir_out updated.
  - Timer cleared.
  - gate_open rises 1 cycle after the request is sampled.
- Denials:
  - deny_in = (state==IDLE) & req_in & full.
  - deny_out = (state==IDLE) & req_out & (count==0).
  - Both are combinational on registered state/count. No grant is issued for a denied lane.
- OPEN_IN:
  - Timer increments each cycle.
  - pass_in=1: count+1, go CLOSING.
  - Else if timer==OPEN_CYCLES-1: timeout pulse, go CLOSING, count unchanged.
  - pass_in coincident with the terminal timer cycle: the pass wins, no timeout.
  - pass_out ignored.
- OPEN_OUT: symmetric; pass_out decrements count, pass_in ignored.
- CLOSING:
  - gate_open=0; timer counts to CLOSE_CYCLES-1, then IDLE.
  - Requests and passes are ignored; requests stay pending and are arbitrated on return to IDLE.
- Passes in IDLE are ignored (car without grant); count unchanged.
- Count arithmetic:
  - Modifications occur only as above, so no wrap is possible.
  - Defensively saturate at CAPACITY and at 0.
- full is combinational from count.
- Minimum grant-to-grant period: 1 (grant edge) + ≥1 open cycle + CLOSE_CYCLES + 1 IDLE cycle.

Test Plan:
Parameters for all scenarios: CAPACITY=3, OPEN_CYCLES=8, CLOSE_CYCLES=4.
- Reset then single entry: req_in=1 → grant_in pulse 1 cycle, gate_open=1; pass_in on 3rd open cycle → count=1, gate_open=0, IDLE after 4 closing cycles.
- Tie round-robin: req_in=req_out=1 with count=2, dir_out=1 → grant_in first, count=3. Next IDLE with both requests asserted: entry is ineligible (full), so grant_out. With count=2 and both requests asserted after an exit grant (dir_out=1) → grant_in.
- Capacity limit: count=3, req_in=1 → deny_in=1 continuously, no grant_in, gate_open stays 0, full=1. An exit pass_out then drops count to 2 and the next IDLE grants entry.
- Timeout: grant_in with no pass → timeout pulse on 8th open cycle, count unchanged, CLOSING 4 cycles. Separately, pass_in on that same terminal cycle → count+1, no timeout.
- Empty exit and stray passes: count=0, req_out=1 → deny_out=1, no grant. pass_out or pass_in in IDLE, or pass_out during OPEN_IN → count unchanged.
- Reset mid-open: assert reset_n=0 during OPEN_OUT → gate_open=0 asynchronously, count=0, dir_out=1; on release with req_in=1 → grant_in on first edge.
